// File: rtl/onehot_dec_pkg.sv
// Shared types and helpers for the one-hot select/strobe generator.
// No state. Purely combinational helpers, so there is no latency and no backpressure.
package onehot_dec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam int HOLD_W    = 8;
    localparam int SEL_W_MAX = 8;
    localparam int OH_W_MAX  = 1 << SEL_W_MAX;

    // Callers truncate the result to 2^N bits with a size cast.
    function automatic logic [OH_W_MAX-1:0] onehot(input logic [SEL_W_MAX-1:0] sel);
        logic [OH_W_MAX-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Dwell counter for scan mode: strobes step every HOLD cycles while run is high, and wrap on the last line.
// step/wrap are combinational off the counter flop. There is no backpressure, and dropping run clears the dwell.
module scan_counter
    import onehot_dec_pkg::*;
#(
    parameter int N    = 3,
    parameter int HOLD = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic [N-1:0] idx,
    output logic         step,
    output logic         wrap,
    output logic [N-1:0] idx_nxt
);

    localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD - 1);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;
    logic              at_end;

    always_comb begin
        at_end  = (cnt_q == LAST);
        step    = run & at_end;
        wrap    = step & (idx == {N{1'b1}});
        idx_nxt = idx + N'(1);
        // Any cycle that is not a continuing scan leaves the count at zero, so scan entry starts a fresh dwell.
        if (!run || at_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/onehot_decoder_scan.sv
// Registered N-to-2^N one-hot decoder that has a direct load mode and an autonomous scan mode.
// The output updates one cycle after the inputs. There is no backpressure, and en=0 blanks the output on the next edge.
module onehot_decoder_scan
    import onehot_dec_pkg::*;
#(
    parameter int N    = 3,
    parameter int HOLD = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic            load,
    input  logic [N-1:0]    sel,
    output logic [2**N-1:0] y,
    output logic [N-1:0]    idx,
    output logic            valid,
    output logic            wrap
);

    localparam int OUT_W = 2**N;

    state_e           state_q, state_d;
    logic [OUT_W-1:0] y_q, y_d;
    logic [N-1:0]     idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;

    logic             scan_run;
    logic             scan_step;
    logic             scan_wrap;
    logic [N-1:0]     scan_idx_nxt;

    // The counter advances only while the scan is going to continue past this edge.
    assign scan_run = (state_q == SCAN) & en & mode;

    scan_counter #(
        .N    (N),
        .HOLD (HOLD)
    ) u_scan_counter (
        .clk     (clk),
        .rst     (rst),
        .run     (scan_run),
        .idx     (idx_q),
        .step    (scan_step),
        .wrap    (scan_wrap),
        .idx_nxt (scan_idx_nxt)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;

        if (!en) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DIRECT: begin
                    if (mode) begin
                        state_d = SCAN;
                        idx_d   = '0;
                        valid_d = 1'b1;
                    end else if (load) begin
                        state_d = DIRECT;
                        idx_d   = sel;
                        valid_d = 1'b1;
                    end
                end
                SCAN: begin
                    if (!mode) begin
                        state_d = DIRECT;
                    end else if (scan_step) begin
                        idx_d  = scan_idx_nxt;
                        wrap_d = scan_wrap;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end

        // y is derived from idx and valid, so it can never carry more than one set bit.
        y_d = valid_d ? OUT_W'(onehot(SEL_W_MAX'(idx_d))) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y     = y_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_onehot_decoder_scan.sv
// Scoreboard bench: two decoders (HOLD=1 and HOLD=3) share one stimulus stream and are checked against an arithmetic reference.
module tb_onehot_decoder_scan;

    localparam int N  = 3;
    localparam int H1 = 1;
    localparam int H3 = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         mode = 1'b0;
    logic         load = 1'b0;
    logic [N-1:0] sel = '0;

    logic [7:0] y1, y3;
    logic [2:0] idx1, idx3;
    logic       valid1, valid3, wrap1, wrap3;

    always #5 clk = ~clk;

    onehot_decoder_scan #(.N(N), .HOLD(H1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel),
        .y(y1), .idx(idx1), .valid(valid1), .wrap(wrap1)
    );

    onehot_decoder_scan #(.N(N), .HOLD(H3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel),
        .y(y3), .idx(idx3), .valid(valid3), .wrap(wrap3)
    );

    // st: 0 idle, 1 direct, 2 scan. t counts cycles since scan entry.
    typedef struct {
        int st;
        int idx;
        bit valid;
        bit wrap;
        int t;
    } model_t;

    typedef struct {
        logic [7:0] y;
        logic [2:0] idx;
        logic       valid;
        logic       wrap;
    } exp_t;

    exp_t   q1[$];
    exp_t   q3[$];
    model_t m1 = '{0, 0, 1'b0, 1'b0, 0};
    model_t m3 = '{0, 0, 1'b0, 1'b0, 0};
    int     n_checks = 0;
    int     n_fail = 0;
    bit     md_cur = 1'b0;

    function automatic model_t mstep(model_t m, int hold, bit r, bit e, bit md, bit ld, int s);
        model_t n = m;
        n.wrap = 1'b0;
        if (r) begin
            n.st = 0; n.idx = 0; n.valid = 1'b0; n.t = 0;
        end else if (!e) begin
            n.st = 0; n.valid = 1'b0;
        end else if (m.st == 2) begin
            if (!md) begin
                n.st = 1;
            end else begin
                n.t    = m.t + 1;
                n.idx  = (n.t / hold) % 8;
                n.wrap = ((n.t % (hold * 8)) == 0);
            end
        end else if (md) begin
            n.st = 2; n.t = 0; n.idx = 0; n.valid = 1'b1;
        end else if (ld) begin
            n.st = 1; n.idx = s; n.valid = 1'b1;
        end
        return n;
    endfunction

    function automatic exp_t to_exp(model_t m);
        exp_t e;
        e.y     = m.valid ? 8'(1 << m.idx) : 8'h00;
        e.idx   = 3'(m.idx);
        e.valid = m.valid;
        e.wrap  = m.wrap;
        return e;
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic cyc(bit r, bit e, bit md, bit ld, int s);
        @(negedge clk);
        rst  = r;
        en   = e;
        mode = md;
        load = ld;
        sel  = s[2:0];
        m1 = mstep(m1, H1, r, e, md, ld, s);
        m3 = mstep(m3, H3, r, e, md, ld, s);
        q1.push_back(to_exp(m1));
        q3.push_back(to_exp(m3));
    endtask

    // Monitor: pops one expectation per DUT per clock, and also checks the one-hot invariant.
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("h1_y", y1, e.y);
                chk("h1_idx", {5'b0, idx1}, {5'b0, e.idx});
                chk("h1_valid", {7'b0, valid1}, {7'b0, e.valid});
                chk("h1_wrap", {7'b0, wrap1}, {7'b0, e.wrap});
            end
            if (q3.size() > 0) begin
                e = q3.pop_front();
                chk("h3_y", y3, e.y);
                chk("h3_idx", {5'b0, idx3}, {5'b0, e.idx});
                chk("h3_valid", {7'b0, valid3}, {7'b0, e.valid});
                chk("h3_wrap", {7'b0, wrap3}, {7'b0, e.wrap});
            end
            ok = valid1 ? (y1 === 8'(1 << idx1)) : (y1 === 8'h00);
            chk("h1_onehot_inv", {7'b0, ok}, 8'h01);
            ok = valid3 ? (y3 === 8'(1 << idx3)) : (y3 === 8'h00);
            chk("h3_onehot_inv", {7'b0, ok}, 8'h01);
        end
    end

    initial begin
        // Reset, then idle with en low.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // Direct sweep, then hold at the last value.
        for (int s = 0; s < 8; s++) cyc(0, 1, 0, 1, s);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 5);
        // Long scan covering several HOLD=1 wraps and two HOLD=3 periods.
        repeat (50) cyc(0, 1, 1, 0, 3);
        // Leave, re-enter scan, and drop en at idx 4 of the HOLD=1 unit.
        cyc(0, 0, 0, 0, 0);
        repeat (5) cyc(0, 1, 1, 1, 6);
        cyc(0, 0, 1, 0, 0);
        // Re-enable into scan, then reset at idx 7.
        repeat (8) cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        // Scan to idx 5, drop mode and hold, then load sel=2.
        repeat (6) cyc(0, 1, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 7);
        cyc(0, 1, 0, 1, 2);
        cyc(0, 1, 0, 0, 0);
        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) md_cur = ~md_cur;
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) != 0),
                md_cur, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end
        @(posedge clk);
        #3;
        n_checks++;
        if (q1.size() != 0 || q3.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q1.size(), q3.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
